// File: rtl/gf_add_arbiter.sv
// gf_add_arbiter: shares one gf_rca_adder among NUM_REQ requesters.
//
// Each cycle a round-robin search (starting at rr_ptr, wrapping upward)
// picks one pending requester, routes its operands and mode through the
// shared adder, and captures the result in a one-entry output register
// guarded by a valid/ready handshake.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous active-high reset
//   req_valid      per-requester operation pending
//   req_ready      one-hot accept (combinational), 0 when nothing accepted
//   req_gf_option  per-requester mode: 1 = GF(2) XOR add, 0 = binary add
//   req_a, req_b   operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid      output register holds a result
//   out_ready      consumer takes the result
//   out_sum        registered adder result
//   out_id         index of the requester that produced out_sum
//   out_gf_option  mode used for out_sum
//   op_count       (GF_ADD_ARB_STAT_EN only) number of accepts, wraps
//   gf_count       (GF_ADD_ARB_STAT_EN only) number of GF-mode accepts, wraps
//
// Configuration macro: GF_ADD_ARB_STAT_EN adds the two statistics counters.
// Arbitration and datapath are identical with or without it.

// gf_rca_adder: ripple-carry adder whose carry chain is suppressed in GF(2)
// mode so that the sum degenerates to a bitwise XOR. The final carry out
// is not produced at all, which gives the modulo 2**DATA_WIDTH result.
module gf_rca_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  gf_option,
  output logic [DATA_WIDTH-1:0] sum
);

  logic [DATA_WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ (carry[i] & ~gf_option);
    if (i < DATA_WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

module gf_add_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_gf_option,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_sum,
  output logic [ID_WIDTH-1:0]             out_id,
`ifdef GF_ADD_ARB_STAT_EN
  output logic [31:0]                     op_count,
  output logic [31:0]                     gf_count,
`endif
  output logic                            out_gf_option
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic                  out_gf_option_q, out_gf_option_d;

  logic                  found;
  int                    grant_int;
  logic                  can_accept;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  sel_gf;
  logic [DATA_WIDTH-1:0] adder_sum;

  // Round-robin search: walk offsets 0..NUM_REQ-1 from the pointer and keep
  // the first pending requester. An out-of-range pointer restarts at 0.
  always_comb begin
    int ptr_int;
    int idx;
    found     = 1'b0;
    grant_int = 0;
    idx       = 0;
    ptr_int   = int'(rr_ptr_q);
    if (ptr_int >= NUM_REQ) begin
      ptr_int = 0;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_int + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == idx) && req_valid[i]) begin
          found     = 1'b1;
          grant_int = i;
        end
      end
    end
  end

  // The output register can take a new result when empty, or when full and
  // being drained this very cycle (back-to-back, no bubble). Reset blocks
  // any accept so that a pending result is simply dropped.
  always_comb begin
    can_accept = (state_q == EMPTY) || ((state_q == FULL) && out_ready);
    accept     = !rst && can_accept && found;
  end

  // One-hot ready to the winner plus the operand mux into the shared adder.
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_gf    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == grant_int) begin
        req_ready[i] = accept;
        sel_a        = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b        = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_gf       = req_gf_option[i];
      end
    end
  end

  gf_rca_adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_adder (
    .a         (sel_a),
    .b         (sel_b),
    .gf_option (sel_gf),
    .sum       (adder_sum)
  );

  // Next-state for the output register, FSM and round-robin pointer.
  // The pointer only moves on an accept, to the slot after the winner.
  always_comb begin
    int nxt;
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    out_sum_d       = out_sum_q;
    out_id_d        = out_id_q;
    out_gf_option_d = out_gf_option_q;
    nxt             = grant_int + 1;
    if (nxt >= NUM_REQ) begin
      nxt = 0;
    end
    if (accept) begin
      state_d         = FULL;
      out_sum_d       = adder_sum;
      out_id_d        = ID_WIDTH'(grant_int);
      out_gf_option_d = sel_gf;
      rr_ptr_d        = ID_WIDTH'(nxt);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= EMPTY;
      rr_ptr_q        <= '0;
      out_sum_q       <= '0;
      out_id_q        <= '0;
      out_gf_option_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      out_sum_q       <= out_sum_d;
      out_id_q        <= out_id_d;
      out_gf_option_q <= out_gf_option_d;
    end
  end

  assign out_valid     = (state_q == FULL);
  assign out_sum       = out_sum_q;
  assign out_id        = out_id_q;
  assign out_gf_option = out_gf_option_q;

`ifdef GF_ADD_ARB_STAT_EN
  logic [31:0] op_count_q, op_count_d;
  logic [31:0] gf_count_q, gf_count_d;

  // Counters wrap naturally at 32 bits.
  always_comb begin
    op_count_d = op_count_q;
    gf_count_d = gf_count_q;
    if (accept) begin
      op_count_d = op_count_q + 32'd1;
      if (sel_gf) begin
        gf_count_d = gf_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
      gf_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
      gf_count_q <= gf_count_d;
    end
  end

  assign op_count = op_count_q;
  assign gf_count = gf_count_q;
`endif

endmodule

// File: tb/tb_gf_add_arbiter.sv
// tb_gf_add_arbiter: self-checking bench for gf_add_arbiter.
// A behavioural model (round-robin search by modulo arithmetic, sums by
// plain arithmetic) is compared against the DUT every cycle, with directed
// scenarios pinning literal values, followed by a randomized phase.
module tb_gf_add_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_gf_option;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_sum;
  logic [IW-1:0]     out_id;
  logic              out_gf_option;
`ifdef GF_ADD_ARB_STAT_EN
  logic [31:0]       op_count;
  logic [31:0]       gf_count;
`endif

  gf_add_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .ID_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_gf_option(req_gf_option),
    .req_a        (req_a),
    .req_b        (req_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_id       (out_id),
`ifdef GF_ADD_ARB_STAT_EN
    .op_count     (op_count),
    .gf_count     (gf_count),
`endif
    .out_gf_option(out_gf_option)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side drive state
  logic [NR-1:0] vvalid;
  logic [NR-1:0] vgf;
  logic [DW-1:0] va [NR];
  logic [DW-1:0] vb [NR];

  // Behavioural model state
  logic          m_valid;
  logic [DW-1:0] m_sum;
  int            m_id;
  logic          m_gf;
  int            m_ptr;
  logic [31:0]   m_ops;
  logic [31:0]   m_gfs;
  logic          m_acc;
  int            m_g;

  // Snapshot of DUT outputs taken at the check point of the last cycle
  logic          s_valid;
  logic [DW-1:0] s_sum;
  logic [IW-1:0] s_id;
  logic          s_gf;
  logic [NR-1:0] s_ready;
  logic [31:0]   s_ops;
  logic [31:0]   s_gfs;

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int modelGrant(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] modelSum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic gf);
    longint s;
    if (gf) return a ^ b;
    s = longint'(a) + longint'(b);
    return DW'(s % (longint'(1) << DW));
  endfunction

  task automatic modelReset();
    m_valid = 1'b0;
    m_sum   = '0;
    m_id    = 0;
    m_gf    = 1'b0;
    m_ptr   = 0;
    m_ops   = '0;
    m_gfs   = '0;
  endtask

  // Compare every DUT output with the model's view of this cycle.
  task automatic checkOutput();
    logic [NR-1:0] exp_ready;
    m_g       = modelGrant(vvalid, m_ptr);
    m_acc     = !rst && (!m_valid || out_ready) && (m_g >= 0);
    exp_ready = m_acc ? (NR'(1) << m_g) : '0;
    cmp("req_ready", req_ready, exp_ready);
    cmp("out_valid", out_valid, m_valid);
    cmp("out_sum", out_sum, m_sum);
    cmp("out_id", out_id, m_id);
    cmp("out_gf_option", out_gf_option, m_gf);
`ifdef GF_ADD_ARB_STAT_EN
    cmp("op_count", op_count, m_ops);
    cmp("gf_count", gf_count, m_gfs);
    s_ops = op_count;
    s_gfs = gf_count;
`endif
    s_valid = out_valid;
    s_sum   = out_sum;
    s_id    = out_id;
    s_gf    = out_gf_option;
    s_ready = req_ready;
  endtask

  // One full cycle: drive at negedge, check, clock, advance the model.
  task automatic applyStimulus(input logic rst_v, input logic ordy);
    @(negedge clk);
    rst       = rst_v;
    out_ready = ordy;
    req_valid = vvalid;
    req_gf_option = vgf;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = va[i];
      req_b[i*DW +: DW] = vb[i];
    end
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    if (rst) begin
      modelReset();
    end else if (m_acc) begin
      m_valid = 1'b1;
      m_sum   = modelSum(va[m_g], vb[m_g], vgf[m_g]);
      m_id    = m_g;
      m_gf    = vgf[m_g];
      m_ptr   = (m_g + 1) % NR;
      m_ops   = m_ops + 1;
      if (vgf[m_g]) m_gfs = m_gfs + 1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] randOperand();
    case ($urandom_range(0, 5))
      0: return '1;
      1: return '0;
      2: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    vvalid = '0;
    vgf = '0;
    for (int i = 0; i < NR; i++) begin
      va[i] = '0;
      vb[i] = '0;
    end
    req_valid = '0;
    req_gf_option = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset state with rst held
    applyStimulus(1'b1, 1'b1);
    cmp("rst_out_valid", s_valid, 1'b0);
    cmp("rst_out_sum", s_sum, 32'h0);

    // Binary add then GF add on requester 0
    vvalid = 4'b0001; va[0] = 32'h0000_000F; vb[0] = 32'h0000_0001; vgf = 4'b0000;
    applyStimulus(1'b0, 1'b1);
    cmp("t1_ready", s_ready, 4'b0001);
    vvalid = 4'b0000;
    applyStimulus(1'b0, 1'b1);
    cmp("t1_valid", s_valid, 1'b1);
    cmp("t1_sum", s_sum, 32'h0000_0010);
    cmp("t1_id", s_id, 0);
    vvalid = 4'b0001; vgf = 4'b0001;
    applyStimulus(1'b0, 1'b1);
    vvalid = 4'b0000;
    applyStimulus(1'b0, 1'b1);
    cmp("t2_sum", s_sum, 32'h0000_000E);
    cmp("t2_gf", s_gf, 1'b1);

    // All requesting: strict rotation, one result per cycle
    applyStimulus(1'b1, 1'b1);
    vvalid = 4'b1111; vgf = 4'b0101;
    for (int i = 0; i < NR; i++) begin
      va[i] = $urandom();
      vb[i] = $urandom();
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1);
      cmp("t3_grant", s_ready, NR'(1) << order[k]);
      if (k > 0) cmp("t3_no_bubble", s_valid, 1'b1);
    end
    vvalid = 4'b0000;
    applyStimulus(1'b0, 1'b1);

    // Back-pressure hold, then drain with wrap of the pointer
    applyStimulus(1'b1, 1'b1);
    vvalid = 4'b0100; vgf = 4'b0000;
    applyStimulus(1'b0, 1'b0);
    cmp("t4_ready2", s_ready, 4'b0100);
    vvalid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0);
      cmp("t4_hold_ready", s_ready, 4'b0000);
      cmp("t4_hold_id", s_id, 2);
      cmp("t4_hold_valid", s_valid, 1'b1);
    end
    applyStimulus(1'b0, 1'b1);
    cmp("t4_wrap_ready", s_ready, 4'b0001);
    vvalid = 4'b0000;
    applyStimulus(1'b0, 1'b1);
    cmp("t4_wrap_id", s_id, 0);

    // Carry discarded vs XOR at the top of the range
    vvalid = 4'b1000; va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0001; vgf = 4'b0000;
    applyStimulus(1'b0, 1'b1);
    vgf = 4'b1000;
    applyStimulus(1'b0, 1'b1);
    cmp("t5_carry_drop", s_sum, 32'h0000_0000);
    vvalid = 4'b0000;
    applyStimulus(1'b0, 1'b1);
    cmp("t5_xor", s_sum, 32'hFFFF_FFFE);

    // Reset while full; then counters over 5 accepts, 2 of them GF
    vvalid = 4'b0001;
    applyStimulus(1'b0, 1'b1);
    vvalid = 4'b1111; vgf = 4'b1100;
    applyStimulus(1'b1, 1'b1);
    cmp("t6_rst_ready", s_ready, 4'b0000);
    applyStimulus(1'b0, 1'b1);
    cmp("t6_valid_after_rst", s_valid, 1'b0);
    cmp("t6_ptr_after_rst", s_ready, 4'b0001);
`ifdef GF_ADD_ARB_STAT_EN
    cmp("t6_op_zero", s_ops, 32'd0);
`endif
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1);
    vvalid = 4'b0000;
    applyStimulus(1'b0, 1'b1);
`ifdef GF_ADD_ARB_STAT_EN
    cmp("t6_op_count", s_ops, 32'd5);
    cmp("t6_gf_count", s_gfs, 32'd2);
`endif

    // Randomized traffic with withdrawal, back-pressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!vvalid[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            vvalid[i] = 1'b1;
            va[i]     = randOperand();
            vb[i]     = randOperand();
            vgf[i]    = $urandom_range(0, 1) == 1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          vvalid[i] = 1'b0;
        end
      end
      applyStimulus($urandom_range(0, 127) == 0, $urandom_range(0, 3) != 0);
      vvalid = vvalid & ~s_ready;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
